// File: rtl/axi_lite_xbar.sv
// axi_lite_xbar: serialized 1-to-2 AXI-lite address-decoding crossbar (up -> s0 SRAM / s1 UART, unmapped -> DECERR)
//   clk, rst (sync, active-low)
//   up_*  : upstream slave-side AXI-lite port (AR/R/AW/W/B)
//   s0_*  : downstream master port to slave 0 (SRAM)
//   s1_*  : downstream master port to slave 1 (UART)
module axi_lite_xbar #(
    parameter logic [31:0] S0_BASE = 32'h8000_0000,
    parameter logic [31:0] S0_MASK = 32'hF800_0000,
    parameter logic [31:0] S1_BASE = 32'hA000_03F8,
    parameter logic [31:0] S1_MASK = 32'hFFFF_FFF8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] up_araddr,
    input  logic        up_arvalid,
    output logic        up_arready,
    output logic [31:0] up_rdata,
    output logic [1:0]  up_rresp,
    output logic        up_rvalid,
    input  logic        up_rready,
    input  logic [31:0] up_awaddr,
    input  logic        up_awvalid,
    output logic        up_awready,
    input  logic [31:0] up_wdata,
    input  logic [7:0]  up_wstrb,
    input  logic        up_wvalid,
    output logic        up_wready,
    output logic [1:0]  up_bresp,
    output logic        up_bvalid,
    input  logic        up_bready,
    output logic [31:0] s0_araddr,
    output logic        s0_arvalid,
    input  logic        s0_arready,
    input  logic [31:0] s0_rdata,
    input  logic [1:0]  s0_rresp,
    input  logic        s0_rvalid,
    output logic        s0_rready,
    output logic [31:0] s0_awaddr,
    output logic        s0_awvalid,
    input  logic        s0_awready,
    output logic [31:0] s0_wdata,
    output logic [7:0]  s0_wstrb,
    output logic        s0_wvalid,
    input  logic        s0_wready,
    input  logic [1:0]  s0_bresp,
    input  logic        s0_bvalid,
    output logic        s0_bready,
    output logic [31:0] s1_araddr,
    output logic        s1_arvalid,
    input  logic        s1_arready,
    input  logic [31:0] s1_rdata,
    input  logic [1:0]  s1_rresp,
    input  logic        s1_rvalid,
    output logic        s1_rready,
    output logic [31:0] s1_awaddr,
    output logic        s1_awvalid,
    input  logic        s1_awready,
    output logic [31:0] s1_wdata,
    output logic [7:0]  s1_wstrb,
    output logic        s1_wvalid,
    input  logic        s1_wready,
    input  logic [1:0]  s1_bresp,
    input  logic        s1_bvalid,
    output logic        s1_bready
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, ERR_R, ERR_W} state_t;
    localparam logic [1:0] MISS = 2'd2;

    state_t      state, state_n;
    logic        last_wr, aw_done, w_done;
    logic [31:0] addr, wdata;
    logic [7:0]  wstrb;
    logic [1:0]  sel;

    function automatic logic [1:0] dec(input logic [31:0] a);
        return ((a & S0_MASK) == S0_BASE) ? 2'd0 : ((a & S1_MASK) == S1_BASE) ? 2'd1 : MISS;
    endfunction

    logic idle, wr_req, ar_acc, aw_acc, e0, e1;
    logic sel_arready, sel_awready, sel_wready, sel_rvalid, sel_bvalid;
    logic ar_hs, aw_hs, w_hs;
    logic [31:0] sel_rdata;
    logic [1:0]  sel_rresp, sel_bresp;

    assign idle   = state == IDLE;
    assign wr_req = up_awvalid && up_wvalid;
    // Accepts are gated by rst so upstream never sees a ready during reset.
    assign ar_acc = idle && rst && up_arvalid && (!wr_req || last_wr);
    assign aw_acc = idle && rst && wr_req && !ar_acc;

    assign e0 = sel == 2'd0;
    assign e1 = sel == 2'd1;

    assign sel_arready = e0 ? s0_arready : e1 && s1_arready;
    assign sel_awready = e0 ? s0_awready : e1 && s1_awready;
    assign sel_wready  = e0 ? s0_wready  : e1 && s1_wready;
    assign sel_rvalid  = e0 ? s0_rvalid  : e1 && s1_rvalid;
    assign sel_bvalid  = e0 ? s0_bvalid  : e1 && s1_bvalid;
    assign sel_rdata   = e0 ? s0_rdata : e1 ? s1_rdata : '0;
    assign sel_rresp   = e0 ? s0_rresp : e1 ? s1_rresp : 2'b00;
    assign sel_bresp   = e0 ? s0_bresp : e1 ? s1_bresp : 2'b00;

    assign ar_hs = state == RD_ADDR && sel_arready;
    assign aw_hs = state == WR_ADDR && !aw_done && sel_awready;
    assign w_hs  = state == WR_ADDR && !w_done && sel_wready;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = ar_acc ? (dec(up_araddr) == MISS ? ERR_R : RD_ADDR)
                             : aw_acc ? (dec(up_awaddr) == MISS ? ERR_W : WR_ADDR) : IDLE;
            RD_ADDR: state_n = ar_hs ? RD_DATA : RD_ADDR;
            RD_DATA: state_n = (sel_rvalid && up_rready) ? IDLE : RD_DATA;
            // Either channel may finish first or both in the same cycle.
            WR_ADDR: state_n = ((aw_done || aw_hs) && (w_done || w_hs)) ? WR_RESP : WR_ADDR;
            WR_RESP: state_n = (sel_bvalid && up_bready) ? IDLE : WR_RESP;
            ERR_R:   state_n = up_rready ? IDLE : ERR_R;
            ERR_W:   state_n = up_bready ? IDLE : ERR_W;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            last_wr <= 1'b1;
            addr    <= '0;
            wdata   <= '0;
            wstrb   <= '0;
            sel     <= 2'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state <= state_n;
            if (ar_acc) begin
                addr    <= up_araddr;
                sel     <= dec(up_araddr);
                last_wr <= 1'b0;
            end else if (aw_acc) begin
                addr    <= up_awaddr;
                wdata   <= up_wdata;
                wstrb   <= up_wstrb;
                sel     <= dec(up_awaddr);
                last_wr <= 1'b1;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs) w_done <= 1'b1;
        end
    end

    assign up_arready = ar_acc;
    assign up_awready = aw_acc;
    assign up_wready  = aw_acc;
    assign up_rvalid  = (state == RD_DATA && sel_rvalid) || state == ERR_R;
    assign up_rdata   = state == RD_DATA ? sel_rdata : '0;
    assign up_rresp   = state == RD_DATA ? sel_rresp : state == ERR_R ? 2'b11 : 2'b00;
    assign up_bvalid  = (state == WR_RESP && sel_bvalid) || state == ERR_W;
    assign up_bresp   = state == WR_RESP ? sel_bresp : state == ERR_W ? 2'b11 : 2'b00;

    assign s0_araddr  = e0 ? addr : '0;
    assign s0_arvalid = e0 && state == RD_ADDR;
    assign s0_rready  = e0 && state == RD_DATA && up_rready;
    assign s0_awaddr  = e0 ? addr : '0;
    assign s0_awvalid = e0 && state == WR_ADDR && !aw_done;
    assign s0_wdata   = e0 ? wdata : '0;
    assign s0_wstrb   = e0 ? wstrb : '0;
    assign s0_wvalid  = e0 && state == WR_ADDR && !w_done;
    assign s0_bready  = e0 && state == WR_RESP && up_bready;

    assign s1_araddr  = e1 ? addr : '0;
    assign s1_arvalid = e1 && state == RD_ADDR;
    assign s1_rready  = e1 && state == RD_DATA && up_rready;
    assign s1_awaddr  = e1 ? addr : '0;
    assign s1_awvalid = e1 && state == WR_ADDR && !aw_done;
    assign s1_wdata   = e1 ? wdata : '0;
    assign s1_wstrb   = e1 ? wstrb : '0;
    assign s1_wvalid  = e1 && state == WR_ADDR && !w_done;
    assign s1_bready  = e1 && state == WR_RESP && up_bready;
endmodule

// File: tb/tb_axi_lite_xbar.sv
// tb_axi_lite_xbar: directed self-checking bench for axi_lite_xbar
module tb_axi_lite_xbar;
    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] up_araddr = '0, up_awaddr = '0, up_wdata = '0, up_rdata;
    logic        up_arvalid = 0, up_arready, up_rvalid, up_rready = 0;
    logic        up_awvalid = 0, up_awready, up_wvalid = 0, up_wready, up_bvalid, up_bready = 0;
    logic [7:0]  up_wstrb = '0;
    logic [1:0]  up_rresp, up_bresp;
    logic [31:0] s0_araddr, s0_awaddr, s0_wdata, s0_rdata = '0;
    logic [31:0] s1_araddr, s1_awaddr, s1_wdata, s1_rdata = '0;
    logic        s0_arvalid, s0_arready = 0, s0_rvalid = 0, s0_rready, s0_awvalid, s0_awready = 0;
    logic        s0_wvalid, s0_wready = 0, s0_bvalid = 0, s0_bready;
    logic        s1_arvalid, s1_arready = 0, s1_rvalid = 0, s1_rready, s1_awvalid, s1_awready = 0;
    logic        s1_wvalid, s1_wready = 0, s1_bvalid = 0, s1_bready;
    logic [7:0]  s0_wstrb, s1_wstrb;
    logic [1:0]  s0_rresp = 0, s0_bresp = 0, s1_rresp = 0, s1_bresp = 0;
    int total = 0, bad = 0;

    axi_lite_xbar dut (
        .clk(clk), .rst(rst),
        .up_araddr(up_araddr), .up_arvalid(up_arvalid), .up_arready(up_arready),
        .up_rdata(up_rdata), .up_rresp(up_rresp), .up_rvalid(up_rvalid), .up_rready(up_rready),
        .up_awaddr(up_awaddr), .up_awvalid(up_awvalid), .up_awready(up_awready),
        .up_wdata(up_wdata), .up_wstrb(up_wstrb), .up_wvalid(up_wvalid), .up_wready(up_wready),
        .up_bresp(up_bresp), .up_bvalid(up_bvalid), .up_bready(up_bready),
        .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        up_arvalid = 1'b1;
        tick();
        tick();
        total++; if (up_arready !== 1'b0) begin bad++; $display("FAIL rst_arready got=%0h exp=0", up_arready); end
        total++; if (up_rvalid !== 1'b0 || up_bvalid !== 1'b0) begin bad++; $display("FAIL rst_up_valids got=%0h%0h exp=00", up_rvalid, up_bvalid); end
        total++; if ({s0_arvalid, s0_awvalid, s0_wvalid, s1_arvalid, s1_awvalid, s1_wvalid} !== 6'b0) begin bad++; $display("FAIL rst_dn_valids got=%b exp=0", {s0_arvalid, s0_awvalid, s0_wvalid, s1_arvalid, s1_awvalid, s1_wvalid}); end
        total++; if (up_rdata !== 32'h0 || up_rresp !== 2'b0 || up_bresp !== 2'b0) begin bad++; $display("FAIL rst_payload got=%h/%0h/%0h exp=0", up_rdata, up_rresp, up_bresp); end
        up_arvalid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_read_s0();
        up_araddr = 32'h8000_0004; up_arvalid = 1'b1; up_rready = 1'b1;
        s0_arready = 1'b1; s0_rvalid = 1'b1; s0_rdata = 32'hDEAD_BEEF; s0_rresp = 2'b00;
        #1;
        total++; if (up_arready !== 1'b1) begin bad++; $display("FAIL rd_arready got=%0h exp=1", up_arready); end
        tick();
        up_arvalid = 1'b0;
        #1;
        total++; if (s0_arvalid !== 1'b1 || s0_araddr !== 32'h8000_0004) begin bad++; $display("FAIL rd_s0_ar got=%0h/%h exp=1/80000004", s0_arvalid, s0_araddr); end
        total++; if (s1_arvalid !== 1'b0 || up_rvalid !== 1'b0) begin bad++; $display("FAIL rd_early got=%0h/%0h exp=0/0", s1_arvalid, up_rvalid); end
        tick();
        total++; if (up_rvalid !== 1'b1 || up_rdata !== 32'hDEAD_BEEF || up_rresp !== 2'b00) begin bad++; $display("FAIL rd_r got=%0h/%h/%0h exp=1/deadbeef/0", up_rvalid, up_rdata, up_rresp); end
        total++; if (s0_rready !== 1'b1 || s0_arvalid !== 1'b0 || s1_rready !== 1'b0) begin bad++; $display("FAIL rd_rready got=%0h/%0h/%0h exp=1/0/0", s0_rready, s0_arvalid, s1_rready); end
        tick();
        total++; if (up_rvalid !== 1'b0) begin bad++; $display("FAIL rd_done got=%0h exp=0", up_rvalid); end
        s0_arready = 1'b0; s0_rvalid = 1'b0;
    endtask

    task automatic test_write_s1();
        up_awaddr = 32'hA000_03F8; up_wdata = 32'h41; up_wstrb = 8'h01;
        up_awvalid = 1'b1; up_wvalid = 1'b1; up_bready = 1'b1;
        #1;
        total++; if (up_awready !== 1'b1 || up_wready !== 1'b1) begin bad++; $display("FAIL wr_accept got=%0h%0h exp=11", up_awready, up_wready); end
        tick();
        up_awvalid = 1'b0; up_wvalid = 1'b0;
        s1_awready = 1'b1; s1_wready = 1'b0;
        #1;
        total++; if (s1_awvalid !== 1'b1 || s1_wvalid !== 1'b1 || s1_awaddr !== 32'hA000_03F8) begin bad++; $display("FAIL wr_s1_aw got=%0h/%0h/%h exp=1/1/a00003f8", s1_awvalid, s1_wvalid, s1_awaddr); end
        total++; if (s1_wdata !== 32'h41 || s1_wstrb !== 8'h01 || s0_awvalid !== 1'b0) begin bad++; $display("FAIL wr_s1_w got=%h/%h/%0h exp=41/01/0", s1_wdata, s1_wstrb, s0_awvalid); end
        tick();
        s1_awready = 1'b0; s1_wready = 1'b1;
        #1;
        total++; if (s1_awvalid !== 1'b0 || s1_wvalid !== 1'b1 || s1_wdata !== 32'h41) begin bad++; $display("FAIL wr_w_held got=%0h/%0h/%h exp=0/1/41", s1_awvalid, s1_wvalid, s1_wdata); end
        tick();
        s1_wready = 1'b0;
        #1;
        total++; if (s1_wvalid !== 1'b0 || up_bvalid !== 1'b0) begin bad++; $display("FAIL wr_wait_b got=%0h/%0h exp=0/0", s1_wvalid, up_bvalid); end
        s1_bvalid = 1'b1; s1_bresp = 2'b00;
        #1;
        total++; if (up_bvalid !== 1'b1 || up_bresp !== 2'b00 || s1_bready !== 1'b1) begin bad++; $display("FAIL wr_b got=%0h/%0h/%0h exp=1/0/1", up_bvalid, up_bresp, s1_bready); end
        tick();
        s1_bvalid = 1'b0;
        #1;
        total++; if (up_bvalid !== 1'b0) begin bad++; $display("FAIL wr_done got=%0h exp=0", up_bvalid); end
    endtask

    task automatic test_miss();
        up_araddr = 32'h0000_0000; up_arvalid = 1'b1; up_rready = 1'b1;
        tick();
        up_arvalid = 1'b0;
        #1;
        total++; if (s0_arvalid !== 1'b0 || s1_arvalid !== 1'b0) begin bad++; $display("FAIL miss_r_dn got=%0h%0h exp=00", s0_arvalid, s1_arvalid); end
        total++; if (up_rvalid !== 1'b1 || up_rresp !== 2'b11 || up_rdata !== 32'h0) begin bad++; $display("FAIL miss_r got=%0h/%0h/%h exp=1/3/0", up_rvalid, up_rresp, up_rdata); end
        tick();
        total++; if (up_rvalid !== 1'b0) begin bad++; $display("FAIL miss_r_done got=%0h exp=0", up_rvalid); end
        up_awaddr = 32'h1000_0000; up_awvalid = 1'b1; up_wvalid = 1'b1; up_bready = 1'b1;
        tick();
        up_awvalid = 1'b0; up_wvalid = 1'b0;
        #1;
        total++; if (s0_awvalid !== 1'b0 || s1_awvalid !== 1'b0 || s0_wvalid !== 1'b0 || s1_wvalid !== 1'b0) begin bad++; $display("FAIL miss_w_dn got=%0h%0h%0h%0h exp=0000", s0_awvalid, s1_awvalid, s0_wvalid, s1_wvalid); end
        total++; if (up_bvalid !== 1'b1 || up_bresp !== 2'b11) begin bad++; $display("FAIL miss_b got=%0h/%0h exp=1/3", up_bvalid, up_bresp); end
        tick();
        total++; if (up_bvalid !== 1'b0) begin bad++; $display("FAIL miss_b_done got=%0h exp=0", up_bvalid); end
    endtask

    task automatic test_arbitration();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        up_araddr = 32'h8000_0008; up_arvalid = 1'b1;
        up_awaddr = 32'h8000_000C; up_wdata = 32'h1234_5678; up_wstrb = 8'h0F;
        up_awvalid = 1'b1; up_wvalid = 1'b1; up_rready = 1'b1; up_bready = 1'b1;
        #1;
        total++; if (up_arready !== 1'b1 || up_awready !== 1'b0 || up_wready !== 1'b0) begin bad++; $display("FAIL arb_first got=%0h%0h%0h exp=100", up_arready, up_awready, up_wready); end
        tick();
        up_arvalid = 1'b0;
        s0_arready = 1'b1; s0_rvalid = 1'b1; s0_rdata = 32'h0000_1234;
        #1;
        total++; if (up_awready !== 1'b0) begin bad++; $display("FAIL arb_busy got=%0h exp=0", up_awready); end
        tick();
        total++; if (up_rdata !== 32'h0000_1234) begin bad++; $display("FAIL arb_rdata got=%h exp=00001234", up_rdata); end
        tick();
        s0_arready = 1'b0; s0_rvalid = 1'b0;
        #1;
        total++; if (up_awready !== 1'b1 || up_wready !== 1'b1) begin bad++; $display("FAIL arb_second got=%0h%0h exp=11", up_awready, up_wready); end
        tick();
        up_awvalid = 1'b0; up_wvalid = 1'b0;
        s0_awready = 1'b1; s0_wready = 1'b1;
        #1;
        total++; if (s0_awvalid !== 1'b1 || s0_awaddr !== 32'h8000_000C || s0_wdata !== 32'h1234_5678 || s0_wstrb !== 8'h0F) begin bad++; $display("FAIL arb_s0_w got=%0h/%h/%h/%h exp=1/8000000c/12345678/0f", s0_awvalid, s0_awaddr, s0_wdata, s0_wstrb); end
        tick();
        s0_awready = 1'b0; s0_wready = 1'b0; s0_bvalid = 1'b1;
        #1;
        total++; if (up_bvalid !== 1'b1 || s0_awvalid !== 1'b0 || s0_wvalid !== 1'b0) begin bad++; $display("FAIL arb_b got=%0h/%0h/%0h exp=1/0/0", up_bvalid, s0_awvalid, s0_wvalid); end
        tick();
        s0_bvalid = 1'b0;
    endtask

    task automatic test_stall();
        int beats = 0;
        up_araddr = 32'h8000_0010; up_arvalid = 1'b1; up_rready = 1'b1;
        tick();
        up_arvalid = 1'b0; s0_arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (s0_arvalid !== 1'b1 || s0_araddr !== 32'h8000_0010) begin bad++; $display("FAIL stall_ar%0d got=%0h/%h exp=1/80000010", i, s0_arvalid, s0_araddr); end
            tick();
        end
        s0_arready = 1'b1;
        #1;
        total++; if (s0_arvalid !== 1'b1 || s0_araddr !== 32'h8000_0010) begin bad++; $display("FAIL stall_ar3 got=%0h/%h exp=1/80000010", s0_arvalid, s0_araddr); end
        tick();
        s0_arready = 1'b0; s0_rvalid = 1'b1; s0_rdata = 32'hCAFE_F00D; up_rready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (s0_rready !== 1'b0 || up_rvalid !== 1'b1 || up_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL stall_r%0d got=%0h/%0h/%h exp=0/1/cafef00d", i, s0_rready, up_rvalid, up_rdata); end
            if (up_rvalid && up_rready) beats++;
            tick();
        end
        up_rready = 1'b1;
        #1;
        total++; if (s0_rready !== 1'b1) begin bad++; $display("FAIL stall_rready got=%0h exp=1", s0_rready); end
        if (up_rvalid && up_rready) beats++;
        tick();
        if (up_rvalid && up_rready) beats++;
        total++; if (beats !== 1) begin bad++; $display("FAIL stall_beats got=%0d exp=1", beats); end
        s0_rvalid = 1'b0;
    endtask

    task automatic test_reset_mid();
        up_araddr = 32'h8000_0020; up_arvalid = 1'b1; up_rready = 1'b0;
        s0_arready = 1'b1;
        tick();
        up_arvalid = 1'b0;
        tick();
        s0_arready = 1'b0; s0_rvalid = 1'b1; s0_rdata = 32'h7777_7777;
        #1;
        total++; if (up_rvalid !== 1'b1) begin bad++; $display("FAIL mid_in_rdata got=%0h exp=1", up_rvalid); end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++; if (up_rvalid !== 1'b0 || s0_arvalid !== 1'b0 || s0_rready !== 1'b0 || up_bvalid !== 1'b0) begin bad++; $display("FAIL mid_abort got=%0h%0h%0h%0h exp=0000", up_rvalid, s0_arvalid, s0_rready, up_bvalid); end
        up_araddr = 32'h8000_0024; up_arvalid = 1'b1; up_rready = 1'b1;
        s0_arready = 1'b1; s0_rdata = 32'h5555_AAAA;
        #1;
        total++; if (up_arready !== 1'b1) begin bad++; $display("FAIL mid_fresh_acc got=%0h exp=1", up_arready); end
        tick();
        up_arvalid = 1'b0;
        #1;
        total++; if (s0_araddr !== 32'h8000_0024) begin bad++; $display("FAIL mid_fresh_addr got=%h exp=80000024", s0_araddr); end
        tick();
        total++; if (up_rvalid !== 1'b1 || up_rdata !== 32'h5555_AAAA) begin bad++; $display("FAIL mid_fresh_r got=%0h/%h exp=1/5555aaaa", up_rvalid, up_rdata); end
        tick();
        s0_arready = 1'b0; s0_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_s0();
        test_write_s1();
        test_miss();
        test_arbitration();
        test_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
